pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Timing and sequencing controller for the video test-pattern datapath.
- Generates 640x480@60 raster timing (800x525 total) and pixel coordinates, and selects which test pattern the pixel generator draws.
- Patterns are either fixed or auto-cycled every N frames; reconfiguration is accepted via valid/ready and applied only on a frame boundary.
- Sits between the clock/reset infrastructure and the pattern pixel generator; drives vsync/hsync/de directly to the video output.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- SYNC_ACTIVE_LOW, 1, sync polarity; 1 means syncs are driven 0 when asserted
- NUM_PATTERNS, 8, pattern count; PSEL_W = clog2(NUM_PATTERNS)
- FRAMES_PER_PATTERN, 60, frames per pattern in auto mode

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  asynchronous reset, active-high
- en_in  in  1  run request; level-sensitive
- cfg_valid_in  in  1  configuration request
- cfg_ready_out  out  1  configuration accepted when high together with cfg_valid_in
- cfg_auto_in  in  1  1 = auto-cycle, 0 = fixed pattern
- cfg_pattern_in  in  PSEL_W  fixed pattern, or auto start pattern
- vsync_out  out  1  vertical sync (polarity per SYNC_ACTIVE_LOW)
- hsync_out  out  1  horizontal sync (polarity per SYNC_ACTIVE_LOW)
- de_out  out  1  data enable
- x_out  out  10  pixel column
- y_out  out  10  pixel line
- frame_start_out  out  1  one-cycle pulse at pixel (0,0)
- pattern_sel_out  out  PSEL_W  active pattern

Behaviour:
- Reset values:
  - syncs deasserted (1 when SYNC_ACTIVE_LOW = 1)
  - de_out = 0, x_out = 0, y_out = 0, frame_start_out = 0
  - pattern_sel_out = 0, cfg_ready_out = 1
  - mode = fixed; FSM in IDLE
- Outputs are registered and mutually coherent: x/y/de/sync/frame_start all describe the same pixel.
- Counters h = 0..H_TOTAL-1 and v = 0..V_TOTAL-1; h wraps to 0 and increments v; v wraps to 0 after the last line.
- Decode:
  - de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751
  - vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491, for whole lines
  - x_out/y_out carry the raw counters, including blanking
- FSM:
  - IDLE: counters held at 0; syncs deasserted; de_out = 0. If en_in = 1, go to RUN; the first output cycle is (0,0) with frame_start_out = 1.
  - RUN: counters advance every clock. If en_in = 0, go to DRAIN.
  - DRAIN: counters keep advancing. After the output of pixel (H_TOTAL-1, V_TOTAL-1), go to IDLE. If en_in returns to 1 during DRAIN, go back to RUN with no raster glitch.
- Frame boundary = output of the last pixel (799, 524).
- Configuration handshake:
  - cfg_ready_out = !pending.
  - Handshake captures {cfg_auto_in, cfg_pattern_in} into the pending register.
  - In IDLE, pending is applied on the next cycle.
  - Otherwise pending is applied at the frame boundary, so the new pattern_sel_out is valid from (0,0) of the next frame.
  - Applying pending clears it and resets the frame counter.
  - cfg_pattern_in >= NUM_PATTERNS is clamped to 0.
- Auto mode:
  - Frame counter increments at each frame boundary.
  - When it reaches FRAMES_PER_PATTERN-1 at a boundary, pattern_sel_out increments (NUM_PATTERNS-1 wraps to 0) and the counter clears.
  - If a config apply and an auto advance coincide, the config wins.
- Fixed mode: pattern_sel_out is constant.
- Asynchronous reset mid-frame: all state returns to reset values immediately, and any pending config is discarded.

Optional Feature:
- Macro: PATTERN_SEQ_FRAME_CNT_EN.
- Defined:
  - adds port frame_cnt_out (out, 16): count of completed frames since reset
  - increments at each frame boundary, wraps at 0xFFFF, reset value 0
  - holds its value in IDLE
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package pattern_seq_pkg:
  - timing default constants and H_TOTAL/V_TOTAL derivation functions
  - FSM state typedef {IDLE, RUN, DRAIN}
  - config struct {auto, pattern}
- One sub-module, video_timing_gen: h/v counters plus sync/de decode, with clear and advance inputs and a frame-boundary output.
- The FSM, config handshake and pattern selection stay in the top.

Test Plan:
- Reset, then en_in = 1 → frame_start_out pulses once at (0,0); over each line, 640 de cycles and hsync low for exactly 96 cycles starting at x = 656; vsync low on lines 490–491; next frame_start exactly 420000 cycles later.
- Fixed mode, cfg pattern 3 accepted mid-frame at y = 100 → cfg_ready_out = 0 until the boundary; pattern_sel_out changes 0→3 on the cycle frame_start_out = 1.
- Auto mode with FRAMES_PER_PATTERN = 2, NUM_PATTERNS = 4, start 2 → sequence 2,2,3,3,0,0 over 6 frames, changing only at (0,0).
- en_in dropped at (10,200) → raster completes to (799,524), then IDLE with syncs deasserted; re-raising en_in in DRAIN at y = 300 causes no counter discontinuity.
- Assert rst_in asynchronously at (400,250) → outputs reach reset values without waiting for a clock edge; pending config discarded; cfg_ready_out = 1.
- With PATTERN_SEQ_FRAME_CNT_EN → frame_cnt_out = 3 after 3 full frames and holds in IDLE.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared types and default timing constants for the pattern sequencer.
// Raster totals are derived from the four segment widths of each axis.
package pattern_seq_pkg;

   localparam int H_ACTIVE_D           = 640;
   localparam int H_FP_D               = 16;
   localparam int H_SYNC_D             = 96;
   localparam int H_BP_D               = 48;
   localparam int V_ACTIVE_D           = 480;
   localparam int V_FP_D               = 10;
   localparam int V_SYNC_D             = 2;
   localparam int V_BP_D               = 33;
   localparam int SYNC_ACTIVE_LOW_D    = 1;
   localparam int NUM_PATTERNS_D       = 8;
   localparam int FRAMES_PER_PATTERN_D = 60;

   // Storage width for a pattern index; covers any NUM_PATTERNS up to 256.
   localparam int PAT_W_MAX = 8;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } seq_state_e;

   typedef struct packed {
      logic                 auto_mode;
      logic [PAT_W_MAX-1:0] pattern;
   } seq_cfg_t;

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with registered de/sync/frame-start decode.
// start loads pixel (0,0), advance steps one pixel, clear returns to the idle output state.
module video_timing_gen
   import pattern_seq_pkg::*;
#(
   parameter int H_ACTIVE        = H_ACTIVE_D,
   parameter int H_FP            = H_FP_D,
   parameter int H_SYNC          = H_SYNC_D,
   parameter int H_BP            = H_BP_D,
   parameter int V_ACTIVE        = V_ACTIVE_D,
   parameter int V_FP            = V_FP_D,
   parameter int V_SYNC          = V_SYNC_D,
   parameter int V_BP            = V_BP_D,
   parameter int SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_D
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       start_in,
   input  logic       advance_in,
   input  logic       clear_in,
   output logic [9:0] x_out,
   output logic [9:0] y_out,
   output logic       de_out,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       frame_start_out,
   output logic       last_pixel_out
);

   localparam logic [9:0] H_LAST   = 10'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [9:0] V_LAST   = 10'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic       SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

   logic [9:0] h_q, h_d, v_q, v_d;
   logic       de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      h_d  = h_q;
      v_d  = v_q;
      de_d = de_q;
      hs_d = hs_q;
      vs_d = vs_q;
      fs_d = fs_q;
      if (clear_in) begin
         h_d  = '0;
         v_d  = '0;
         de_d = 1'b0;
         hs_d = SYNC_OFF;
         vs_d = SYNC_OFF;
         fs_d = 1'b0;
      end else if (start_in || advance_in) begin
         if (start_in) begin
            h_d = '0;
            v_d = '0;
         end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
         // Decode from the next counter values so every output flop describes the same pixel.
         de_d = (h_d < H_ACT) && (v_d < V_ACT);
         hs_d = ((h_d >= HS_BEGIN) && (h_d < HS_END)) ? !SYNC_OFF : SYNC_OFF;
         vs_d = ((v_d >= VS_BEGIN) && (v_d < VS_END)) ? !SYNC_OFF : SYNC_OFF;
         fs_d = (h_d == '0) && (v_d == '0);
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         h_q  <= '0;
         v_q  <= '0;
         de_q <= 1'b0;
         hs_q <= SYNC_OFF;
         vs_q <= SYNC_OFF;
         fs_q <= 1'b0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         de_q <= de_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         fs_q <= fs_d;
      end
   end

   assign x_out           = h_q;
   assign y_out           = v_q;
   assign de_out          = de_q;
   assign hsync_out       = hs_q;
   assign vsync_out       = vs_q;
   assign frame_start_out = fs_q;
   assign last_pixel_out  = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/pattern_sequencer.sv
// Video test-pattern sequencer: run/drain FSM, frame-aligned config handshake, pattern selection.
// Define PATTERN_SEQ_FRAME_CNT_EN to add the 16-bit frame_cnt_out completed-frame counter.
module pattern_sequencer
   import pattern_seq_pkg::*;
#(
   parameter int H_ACTIVE           = H_ACTIVE_D,
   parameter int H_FP               = H_FP_D,
   parameter int H_SYNC             = H_SYNC_D,
   parameter int H_BP               = H_BP_D,
   parameter int V_ACTIVE           = V_ACTIVE_D,
   parameter int V_FP               = V_FP_D,
   parameter int V_SYNC             = V_SYNC_D,
   parameter int V_BP               = V_BP_D,
   parameter int SYNC_ACTIVE_LOW    = SYNC_ACTIVE_LOW_D,
   parameter int NUM_PATTERNS       = NUM_PATTERNS_D,
   parameter int FRAMES_PER_PATTERN = FRAMES_PER_PATTERN_D,
   localparam int PSEL_W            = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              en_in,
   input  logic              cfg_valid_in,
   output logic              cfg_ready_out,
   input  logic              cfg_auto_in,
   input  logic [PSEL_W-1:0] cfg_pattern_in,
   output logic              vsync_out,
   output logic              hsync_out,
   output logic              de_out,
   output logic [9:0]        x_out,
   output logic [9:0]        y_out,
   output logic              frame_start_out,
   output logic [PSEL_W-1:0] pattern_sel_out
`ifdef PATTERN_SEQ_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_cnt_out
`endif
);

   localparam int                   FCW      = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
   localparam logic [FCW-1:0]       FPP_LAST = FCW'(FRAMES_PER_PATTERN - 1);
   localparam logic [PAT_W_MAX-1:0] PAT_LAST = PAT_W_MAX'(NUM_PATTERNS - 1);

   seq_state_e     state_q, state_d;
   seq_cfg_t       active_q, active_d, pend_q, pend_d;
   logic           pend_valid_q, pend_valid_d;
   logic [FCW-1:0] fpp_cnt_q, fpp_cnt_d;
   logic           tg_start, tg_advance, tg_clear, last_pixel, boundary, cfg_fire;

   video_timing_gen #(
      .H_ACTIVE        (H_ACTIVE),
      .H_FP            (H_FP),
      .H_SYNC          (H_SYNC),
      .H_BP            (H_BP),
      .V_ACTIVE        (V_ACTIVE),
      .V_FP            (V_FP),
      .V_SYNC          (V_SYNC),
      .V_BP            (V_BP),
      .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_timing (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .start_in        (tg_start),
      .advance_in      (tg_advance),
      .clear_in        (tg_clear),
      .x_out           (x_out),
      .y_out           (y_out),
      .de_out          (de_out),
      .hsync_out       (hsync_out),
      .vsync_out       (vsync_out),
      .frame_start_out (frame_start_out),
      .last_pixel_out  (last_pixel)
   );

   always_comb begin
      state_d    = state_q;
      tg_start   = 1'b0;
      tg_advance = 1'b0;
      tg_clear   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en_in) begin
               state_d  = RUN;
               tg_start = 1'b1;
            end
         end
         RUN: begin
            tg_advance = 1'b1;
            if (!en_in) state_d = DRAIN;
         end
         DRAIN: begin
            if (en_in) begin
               state_d    = RUN;
               tg_advance = 1'b1;
            end else if (last_pixel) begin
               state_d  = IDLE;
               tg_clear = 1'b1;
            end else begin
               tg_advance = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            tg_clear = 1'b1;
         end
      endcase
   end

   assign boundary      = (state_q != IDLE) && last_pixel;
   assign cfg_fire      = cfg_valid_in && !pend_valid_q;
   assign cfg_ready_out = !pend_valid_q;

   always_comb begin
      active_d     = active_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      fpp_cnt_d    = fpp_cnt_q;
      // A pending config outranks an auto advance landing on the same boundary.
      if (pend_valid_q && ((state_q == IDLE) || boundary)) begin
         active_d     = pend_q;
         pend_valid_d = 1'b0;
         fpp_cnt_d    = '0;
      end else if (boundary && active_q.auto_mode) begin
         if (fpp_cnt_q == FPP_LAST) begin
            fpp_cnt_d        = '0;
            active_d.pattern = (active_q.pattern == PAT_LAST) ? '0 : active_q.pattern + PAT_W_MAX'(1);
         end else begin
            fpp_cnt_d = fpp_cnt_q + FCW'(1);
         end
      end
      if (cfg_fire) begin
         pend_valid_d     = 1'b1;
         pend_d.auto_mode = cfg_auto_in;
         pend_d.pattern   = (int'(cfg_pattern_in) >= NUM_PATTERNS) ? '0 : PAT_W_MAX'(cfg_pattern_in);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         active_q     <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         fpp_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         fpp_cnt_q    <= fpp_cnt_d;
      end
   end

   assign pattern_sel_out = active_q.pattern[PSEL_W-1:0];

`ifdef PATTERN_SEQ_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (boundary) frame_cnt_d = frame_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) frame_cnt_q <= '0;
      else        frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt_out = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer on a reduced 16x10 raster with 4 patterns, 2 frames each.
// A pixel-index reference model is compared against the DUT on every falling clock edge.
module tb_pattern_sequencer;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int NP = 4, FPP = 2;

   logic       clk_in = 1'b0, rst_in = 1'b1, en_in = 1'b0;
   logic       cfg_valid_in = 1'b0, cfg_auto_in = 1'b0;
   logic [1:0] cfg_pattern_in = 2'd0;
   logic       cfg_ready_out, vsync_out, hsync_out, de_out, frame_start_out;
   logic [9:0] x_out, y_out;
   logic [1:0] pattern_sel_out;
`ifdef PATTERN_SEQ_FRAME_CNT_EN
   logic [15:0] frame_cnt_out;
`endif

   int checks = 0, failures = 0;

   pattern_sequencer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_ACTIVE_LOW(1), .NUM_PATTERNS(NP), .FRAMES_PER_PATTERN(FPP)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in),
      .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
      .cfg_auto_in(cfg_auto_in), .cfg_pattern_in(cfg_pattern_in),
      .vsync_out(vsync_out), .hsync_out(hsync_out), .de_out(de_out),
      .x_out(x_out), .y_out(y_out), .frame_start_out(frame_start_out),
      .pattern_sel_out(pattern_sel_out)
`ifdef PATTERN_SEQ_FRAME_CNT_EN
      , .frame_cnt_out(frame_cnt_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s at %0t: actual=timeout expected=event", name, $time);
   endtask

   // Reference model: raster position as a single pixel index plus a "live" flag.
   bit m_live, m_stopping, m_pend, m_pend_auto, m_auto;
   int m_pix, m_pat, m_pend_pat, m_fcnt, m_frames;

   task automatic model_reset();
      m_live = 0; m_stopping = 0; m_pix = 0;
      m_pend = 0; m_pend_auto = 0; m_pend_pat = 0;
      m_auto = 0; m_pat = 0; m_fcnt = 0; m_frames = 0;
   endtask

   task automatic model_step();
      bit fire, was_live, boundary;
      fire     = cfg_valid_in && !m_pend;
      was_live = m_live;
      boundary = m_live && (m_pix == FRAME - 1);
      if (!m_live) begin
         if (en_in) begin m_live = 1; m_pix = 0; m_stopping = 0; end
      end else if (m_stopping && !en_in && boundary) begin
         m_live = 0; m_pix = 0;
      end else begin
         m_pix = (m_pix + 1) % FRAME;
         m_stopping = !en_in;
      end
      if (m_pend && (!was_live || boundary)) begin
         m_auto = m_pend_auto; m_pat = m_pend_pat; m_fcnt = 0; m_pend = 0;
      end else if (boundary && m_auto) begin
         m_fcnt++;
         if (m_fcnt == FPP) begin m_fcnt = 0; m_pat = (m_pat + 1) % NP; end
      end
      if (boundary) m_frames = (m_frames + 1) % 65536;
      if (fire) begin
         m_pend = 1; m_pend_auto = cfg_auto_in;
         m_pend_pat = (int'(cfg_pattern_in) >= NP) ? 0 : int'(cfg_pattern_in);
      end
   endtask

   function automatic logic [63:0] model_vec();
      int h, v;
      logic [9:0] x, y;
      logic de, hs, vs, fs;
      logic [15:0] fc;
      h = m_pix % HT; v = m_pix / HT;
      if (m_live) begin
         x = 10'(h); y = 10'(v);
         de = (h < HA) && (v < VA);
         hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
         vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
         fs = (m_pix == 0);
      end else begin
         x = '0; y = '0; de = 0; hs = 1; vs = 1; fs = 0;
      end
`ifdef PATTERN_SEQ_FRAME_CNT_EN
      fc = 16'(m_frames);
`else
      fc = 16'd0;
`endif
      return 64'({x, y, de, hs, vs, fs, 2'(m_pat), !m_pend, fc});
   endfunction

   function automatic logic [63:0] dut_vec();
      logic [15:0] fc;
`ifdef PATTERN_SEQ_FRAME_CNT_EN
      fc = frame_cnt_out;
`else
      fc = 16'd0;
`endif
      return 64'({x_out, y_out, de_out, hsync_out, vsync_out, frame_start_out,
                  pattern_sel_out, cfg_ready_out, fc});
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk_in or posedge rst_in);
         if (rst_in) model_reset();
         else        model_step();
      end
   end

   initial forever begin
      @(negedge clk_in);
      if (!rst_in) check("cycle_vs_model", dut_vec(), model_vec());
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog at %0t: actual=running expected=finished", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic wait_xy(input int x, input int y, input int budget, input string name);
      bit hit = 0;
      for (int n = 0; n < budget && !hit; n++) begin
         tick();
         hit = (x_out == 10'(x)) && (y_out == 10'(y));
      end
      if (!hit) timeout(name);
   endtask

   task automatic wait_fs(input int budget, input string name);
      bit hit = 0;
      for (int n = 0; n < budget && !hit; n++) begin
         tick();
         hit = frame_start_out;
      end
      if (!hit) timeout(name);
   endtask

   localparam logic [26:0] IDLE_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};

   initial begin
      int de_cnt, hs_cnt, vs_cnt, fs_cnt, first_hs_x;
      logic [1:0] prev_sel;
      bit hit;
      int exp_seq[6] = '{2, 2, 3, 3, 0, 0};

      repeat (3) tick();
      rst_in = 1'b0;
      check("reset_state", 64'({x_out, y_out, de_out, hsync_out, vsync_out, frame_start_out,
                                pattern_sel_out, cfg_ready_out}), 64'(IDLE_VEC));

      // Raster shape over one full frame.
      en_in = 1'b1;
      wait_fs(5, "first_frame_start");
      check("first_pixel", 64'({x_out, y_out, de_out}), 64'({10'd0, 10'd0, 1'b1}));
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; first_hs_x = -1;
      for (int i = 0; i < FRAME; i++) begin
         de_cnt += int'(de_out);
         fs_cnt += int'(frame_start_out);
         if (!hsync_out) begin
            hs_cnt++;
            if (first_hs_x < 0) first_hs_x = int'(x_out);
         end
         if (!vsync_out) vs_cnt++;
         tick();
      end
      check("frame_period_fs", 64'(frame_start_out), 64'(1));
      check("de_per_frame", 64'(de_cnt), 64'(48));
      check("hsync_low_per_frame", 64'(hs_cnt), 64'(30));
      check("hsync_first_x", 64'(first_hs_x), 64'(10));
      check("vsync_low_per_frame", 64'(vs_cnt), 64'(32));
      check("fs_pulses_per_frame", 64'(fs_cnt), 64'(1));

      // Fixed pattern 3 requested mid-frame.
      wait_xy(0, 3, FRAME + 5, "wait_y3");
      cfg_valid_in = 1'b1; cfg_auto_in = 1'b0; cfg_pattern_in = 2'd3;
      tick();
      cfg_valid_in = 1'b0;
      check("ready_low_while_pending", 64'(cfg_ready_out), 64'(0));
      prev_sel = pattern_sel_out;
      hit = 0;
      for (int n = 0; n < FRAME + 5 && !hit; n++) begin
         tick();
         if (frame_start_out) hit = 1;
         else prev_sel = pattern_sel_out;
      end
      if (!hit) timeout("wait_apply_fs");
      check("psel_before_boundary", 64'(prev_sel), 64'(0));
      check("psel_at_frame_start", 64'(pattern_sel_out), 64'(3));
      check("ready_after_apply", 64'(cfg_ready_out), 64'(1));

      // Auto-cycle starting at pattern 2.
      wait_xy(4, 2, FRAME + 5, "wait_auto_cfg");
      cfg_valid_in = 1'b1; cfg_auto_in = 1'b1; cfg_pattern_in = 2'd2;
      tick();
      cfg_valid_in = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wait_fs(FRAME + 5, "wait_auto_fs");
         check($sformatf("auto_seq_%0d", k), 64'(pattern_sel_out), 64'(exp_seq[k]));
      end

      // Drain, recover in drain without a raster jump, then drain to idle.
      wait_xy(3, 4, FRAME + 5, "wait_drop");
      en_in = 1'b0;
      wait_xy(0, 6, FRAME + 5, "wait_reraise");
      en_in = 1'b1;
      tick();
      check("reraise_continuity", 64'({x_out, y_out}), 64'({10'd1, 10'd6}));
      wait_xy(3, 2, FRAME + 5, "wait_drop2");
      en_in = 1'b0;
      wait_xy(HT - 1, VT - 1, FRAME + 5, "wait_last_pixel");
      tick();
      check("idle_after_drain", 64'({x_out, y_out, de_out, hsync_out, vsync_out, frame_start_out}),
            64'({10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}));
      repeat (5) tick();
      check("idle_hold", 64'({x_out, y_out, de_out, hsync_out, vsync_out}),
            64'({10'd0, 10'd0, 1'b0, 1'b1, 1'b1}));

      // Randomised enable and configuration traffic.
      for (int n = 0; n < 4000; n++) begin
         tick();
         if ($urandom_range(0, 99) < 2) en_in = !en_in;
         cfg_valid_in   = ($urandom_range(0, 39) == 0);
         cfg_auto_in    = 1'($urandom_range(0, 1));
         cfg_pattern_in = 2'($urandom_range(0, 3));
      end
      cfg_valid_in = 1'b0;
      en_in = 1'b1;

      // Asynchronous reset with a config still pending.
      hit = 0;
      for (int n = 0; n < 2 * FRAME + 5 && !hit; n++) begin
         tick();
         hit = cfg_ready_out;
      end
      if (!hit) timeout("wait_ready");
      wait_xy(5, 3, 2 * FRAME + 5, "wait_reset_point");
      cfg_valid_in = 1'b1; cfg_auto_in = 1'b1; cfg_pattern_in = 2'd1;
      tick();
      cfg_valid_in = 1'b0;
      check("pending_before_reset", 64'(cfg_ready_out), 64'(0));
      #2;
      rst_in = 1'b1;
      en_in  = 1'b0;
      #1;
      check("async_reset_state", 64'({x_out, y_out, de_out, hsync_out, vsync_out, frame_start_out,
                                      pattern_sel_out, cfg_ready_out}), 64'(IDLE_VEC));
`ifdef PATTERN_SEQ_FRAME_CNT_EN
      check("async_reset_frame_cnt", 64'(frame_cnt_out), 64'(0));
`endif
      tick();
      tick();
      rst_in = 1'b0;
      en_in  = 1'b1;
      wait_fs(5, "fs_after_reset");
      check("pending_discarded", 64'({pattern_sel_out, cfg_ready_out}), 64'({2'd0, 1'b1}));
`ifdef PATTERN_SEQ_FRAME_CNT_EN
      check("frame_cnt_first", 64'(frame_cnt_out), 64'(0));
`endif
      wait_fs(FRAME + 5, "fs_frame2");
      wait_fs(FRAME + 5, "fs_frame3");
`ifdef PATTERN_SEQ_FRAME_CNT_EN
      check("frame_cnt_two", 64'(frame_cnt_out), 64'(2));
`endif
      en_in = 1'b0;
      wait_xy(HT - 1, VT - 1, FRAME + 5, "wait_final_last");
      tick();
      check("final_idle", 64'({x_out, y_out, de_out}), 64'({10'd0, 10'd0, 1'b0}));
`ifdef PATTERN_SEQ_FRAME_CNT_EN
      check("frame_cnt_three", 64'(frame_cnt_out), 64'(3));
      repeat (20) tick();
      check("frame_cnt_hold_idle", 64'(frame_cnt_out), 64'(3));
`endif
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
